axi_amo_req_adapter: RTL and testbench



---
 rtl/amo_axi_pkg.sv | 77 +++++++
 rtl/axi_amo_req_adapter.sv | 199 +++++++++++++++++++
 tb/tb_axi_amo_req_adapter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amo_axi_pkg.sv
// Shared types for the core-request to AXI4+ATOP adapter: request op codes,
// ATOP encodings, AXI response codes, FSM states and the op-to-atop decode.
package amo_axi_pkg;

   typedef enum logic [3:0] {
      AMO_LOAD  = 4'd0,
      AMO_STORE = 4'd1,
      AMO_LR    = 4'd2,
      AMO_SC    = 4'd3,
      AMO_SWAP  = 4'd4,
      AMO_ADD   = 4'd5,
      AMO_AND   = 4'd6,
      AMO_OR    = 4'd7,
      AMO_XOR   = 4'd8,
      AMO_MAX   = 4'd9,
      AMO_MAXU  = 4'd10,
      AMO_MIN   = 4'd11,
      AMO_MINU  = 4'd12
   } amo_op_e;

   localparam logic [5:0] ATOP_NONE      = 6'b000000;
   localparam logic [5:0] ATOP_SWAP      = 6'b110000;
   localparam logic [5:0] ATOP_LOAD_ADD  = 6'b100000;
   localparam logic [5:0] ATOP_LOAD_CLR  = 6'b100001;
   localparam logic [5:0] ATOP_LOAD_EOR  = 6'b100010;
   localparam logic [5:0] ATOP_LOAD_SET  = 6'b100011;
   localparam logic [5:0] ATOP_LOAD_SMAX = 6'b100100;
   localparam logic [5:0] ATOP_LOAD_SMIN = 6'b100101;
   localparam logic [5:0] ATOP_LOAD_UMAX = 6'b100110;
   localparam logic [5:0] ATOP_LOAD_UMIN = 6'b100111;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_WAIT_B,
      ST_WAIT_R,
      ST_WAIT_BR,
      ST_RSP
   } state_e;

   // AND is issued as an atomic clear, so the W data must be inverted by the caller.
   function automatic logic [5:0] amo_atop(input amo_op_e op);
      case (op)
         AMO_SWAP: return ATOP_SWAP;
         AMO_ADD:  return ATOP_LOAD_ADD;
         AMO_AND:  return ATOP_LOAD_CLR;
         AMO_OR:   return ATOP_LOAD_SET;
         AMO_XOR:  return ATOP_LOAD_EOR;
         AMO_MAX:  return ATOP_LOAD_SMAX;
         AMO_MIN:  return ATOP_LOAD_SMIN;
         AMO_MAXU: return ATOP_LOAD_UMAX;
         AMO_MINU: return ATOP_LOAD_UMIN;
         default:  return ATOP_NONE;
      endcase
   endfunction

   function automatic logic is_read_op(input amo_op_e op);
      return (op == AMO_LOAD) || (op == AMO_LR);
   endfunction

   function automatic logic is_amo_op(input amo_op_e op);
      return amo_atop(op) != ATOP_NONE;
   endfunction

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

endpackage

// File: rtl/axi_amo_req_adapter.sv
// Turns one outstanding core request (load/store/LR/SC/AMO) into a single-beat
// AXI4+ATOP transaction and returns exactly one response for it.
module axi_amo_req_adapter
   import amo_axi_pkg::*;
#(
   parameter int unsigned        AddrWidth      = 48,
   parameter int unsigned        DataWidth      = 64,
   parameter int unsigned        IdWidth        = 4,
   parameter logic [IdWidth-1:0] AxiId          = '0,
   parameter int unsigned        RiscvWordWidth = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic [3:0]             req_op_i,
   input  logic [1:0]             req_size_i,
   input  logic [DataWidth-1:0]   req_data_i,
   input  logic [DataWidth/8-1:0] req_strb_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DataWidth-1:0]   rsp_data_o,
   output logic                   rsp_error_o,
   output logic [AddrWidth-1:0]   mst_aw_addr_o,
   output logic [2:0]             mst_aw_size_o,
   output logic [7:0]             mst_aw_len_o,
   output logic [1:0]             mst_aw_burst_o,
   output logic                   mst_aw_lock_o,
   output logic [5:0]             mst_aw_atop_o,
   output logic [IdWidth-1:0]     mst_aw_id_o,
   output logic                   mst_aw_valid_o,
   input  logic                   mst_aw_ready_i,
   output logic [DataWidth-1:0]   mst_w_data_o,
   output logic [DataWidth/8-1:0] mst_w_strb_o,
   output logic                   mst_w_last_o,
   output logic                   mst_w_valid_o,
   input  logic                   mst_w_ready_i,
   input  logic [1:0]             mst_b_resp_i,
   input  logic                   mst_b_valid_i,
   output logic                   mst_b_ready_o,
   output logic [AddrWidth-1:0]   mst_ar_addr_o,
   output logic [2:0]             mst_ar_size_o,
   output logic [7:0]             mst_ar_len_o,
   output logic [1:0]             mst_ar_burst_o,
   output logic                   mst_ar_lock_o,
   output logic [IdWidth-1:0]     mst_ar_id_o,
   output logic                   mst_ar_valid_o,
   input  logic                   mst_ar_ready_i,
   input  logic [DataWidth-1:0]   mst_r_data_i,
   input  logic [1:0]             mst_r_resp_i,
   input  logic                   mst_r_valid_i,
   output logic                   mst_r_ready_o
);

   state_e                    state_q, state_d;
   amo_op_e                   req_op;
   amo_op_e                   op_q;
   logic [AddrWidth-1:0]      addr_q;
   logic [1:0]                size_q;
   logic [DataWidth-1:0]      data_q;
   logic [DataWidth/8-1:0]    strb_q;
   logic                      aw_sent_q, w_sent_q, b_got_q, r_got_q;
   logic [RiscvWordWidth-1:0] rsp_data_q;
   logic                      rsp_err_q;
   logic                      req_fire, aw_fire, w_fire, b_cap, r_cap;

   assign req_op   = amo_op_e'(req_op_i);
   assign req_fire = req_valid_i && req_ready_o;
   assign aw_fire  = mst_aw_valid_o && mst_aw_ready_i;
   assign w_fire   = mst_w_valid_o && mst_w_ready_i;
   // A second beat on an already-captured channel must never overwrite the result.
   assign b_cap    = mst_b_valid_i && mst_b_ready_o && !b_got_q;
   assign r_cap    = mst_r_valid_i && mst_r_ready_o && !r_got_q;

   assign mst_aw_addr_o  = addr_q;
   assign mst_aw_size_o  = {1'b0, size_q};
   assign mst_aw_len_o   = 8'd0;
   assign mst_aw_burst_o = AXI_BURST_INCR;
   assign mst_aw_lock_o  = (op_q == AMO_SC);
   assign mst_aw_atop_o  = amo_atop(op_q);
   assign mst_aw_id_o    = AxiId;
   assign mst_w_data_o   = (op_q == AMO_AND) ? ~data_q : data_q;
   assign mst_w_strb_o   = strb_q;
   assign mst_w_last_o   = 1'b1;
   assign mst_ar_addr_o  = addr_q;
   assign mst_ar_size_o  = {1'b0, size_q};
   assign mst_ar_len_o   = 8'd0;
   assign mst_ar_burst_o = AXI_BURST_INCR;
   assign mst_ar_lock_o  = (op_q == AMO_LR);
   assign mst_ar_id_o    = AxiId;
   assign rsp_data_o     = rsp_data_q;
   assign rsp_error_o    = rsp_err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      req_ready_o    = 1'b0;
      mst_aw_valid_o = 1'b0;
      mst_w_valid_o  = 1'b0;
      mst_ar_valid_o = 1'b0;
      mst_b_ready_o  = 1'b0;
      mst_r_ready_o  = 1'b0;
      rsp_valid_o    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = !rst_i;
            if (req_valid_i && !rst_i) begin
               state_d = is_read_op(req_op) ? ST_READ : ST_WRITE;
            end
         end
         ST_WRITE: begin
            mst_aw_valid_o = !aw_sent_q;
            mst_w_valid_o  = !w_sent_q;
            if ((aw_sent_q || mst_aw_ready_i) && (w_sent_q || mst_w_ready_i)) begin
               state_d = is_amo_op(op_q) ? ST_WAIT_BR : ST_WAIT_B;
            end
         end
         ST_READ: begin
            mst_ar_valid_o = 1'b1;
            if (mst_ar_ready_i) state_d = ST_WAIT_R;
         end
         ST_WAIT_B: begin
            mst_b_ready_o = 1'b1;
            if (mst_b_valid_i) state_d = ST_RSP;
         end
         ST_WAIT_R: begin
            mst_r_ready_o = 1'b1;
            if (mst_r_valid_i) state_d = ST_RSP;
         end
         ST_WAIT_BR: begin
            mst_b_ready_o = 1'b1;
            mst_r_ready_o = 1'b1;
            if ((b_got_q || mst_b_valid_i) && (r_got_q || mst_r_valid_i)) state_d = ST_RSP;
         end
         ST_RSP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q       <= AMO_LOAD;
         addr_q     <= '0;
         size_q     <= '0;
         data_q     <= '0;
         strb_q     <= '0;
         aw_sent_q  <= 1'b0;
         w_sent_q   <= 1'b0;
         b_got_q    <= 1'b0;
         r_got_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (req_fire) begin
            op_q       <= req_op;
            addr_q     <= req_addr_i;
            size_q     <= req_size_i;
            data_q     <= req_data_i;
            strb_q     <= req_strb_i;
            aw_sent_q  <= 1'b0;
            w_sent_q   <= 1'b0;
            b_got_q    <= 1'b0;
            r_got_q    <= 1'b0;
            rsp_data_q <= '0;
         end
         if (aw_fire) aw_sent_q <= 1'b1;
         if (w_fire) w_sent_q <= 1'b1;
         // SC reports 0 on success (EXOKAY) and 1 on failure, matching RISC-V sc.w/sc.d.
         if (b_cap) begin
            b_got_q <= 1'b1;
            if (op_q == AMO_SC) begin
               rsp_data_q <= {{(RiscvWordWidth-1){1'b0}}, (mst_b_resp_i != AXI_RESP_EXOKAY)};
            end
         end
         if (r_cap) begin
            r_got_q    <= 1'b1;
            rsp_data_q <= mst_r_data_i;
         end
         if (req_fire) begin
            rsp_err_q <= 1'b0;
         end else begin
            rsp_err_q <= rsp_err_q | (b_cap && resp_is_err(mst_b_resp_i))
                                   | (r_cap && resp_is_err(mst_r_resp_i));
         end
      end
   end

endmodule

// File: tb/tb_axi_amo_req_adapter.sv
// Directed bench for axi_amo_req_adapter: a hand-driven AXI slave per scenario,
// with inline expected values computed by hand.
module tb_axi_amo_req_adapter;

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LR    = 4'd2;
   localparam logic [3:0] OP_SC    = 4'd3;
   localparam logic [3:0] OP_ADD   = 4'd5;
   localparam logic [3:0] OP_AND   = 4'd6;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [47:0] req_addr;
   logic [3:0]  req_op;
   logic [1:0]  req_size;
   logic [63:0] req_data;
   logic [7:0]  req_strb;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [63:0] rsp_data;
   logic [47:0] aw_addr, ar_addr;
   logic [2:0]  aw_size, ar_size;
   logic [7:0]  aw_len, ar_len;
   logic [1:0]  aw_burst, ar_burst;
   logic        aw_lock, ar_lock;
   logic [5:0]  aw_atop;
   logic [3:0]  aw_id, ar_id;
   logic        aw_valid, aw_ready, ar_valid, ar_ready;
   logic [63:0] w_data, r_data;
   logic [7:0]  w_strb;
   logic        w_last, w_valid, w_ready;
   logic [1:0]  b_resp, r_resp;
   logic        b_valid, b_ready, r_valid, r_ready;

   int vectors = 0;
   int miscompares = 0;
   int aw_beats = 0, w_beats = 0, ar_beats = 0, b_beats = 0, r_beats = 0;
   int stab_err = 0;
   logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
   logic [47:0] aw_addr_prev = '0, ar_addr_prev = '0;
   logic [63:0] w_data_prev = '0;

   always #5 clk = ~clk;

   axi_amo_req_adapter dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_op_i(req_op), .req_size_i(req_size),
      .req_data_i(req_data), .req_strb_i(req_strb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
      .mst_aw_addr_o(aw_addr), .mst_aw_size_o(aw_size), .mst_aw_len_o(aw_len),
      .mst_aw_burst_o(aw_burst), .mst_aw_lock_o(aw_lock), .mst_aw_atop_o(aw_atop),
      .mst_aw_id_o(aw_id), .mst_aw_valid_o(aw_valid), .mst_aw_ready_i(aw_ready),
      .mst_w_data_o(w_data), .mst_w_strb_o(w_strb), .mst_w_last_o(w_last),
      .mst_w_valid_o(w_valid), .mst_w_ready_i(w_ready),
      .mst_b_resp_i(b_resp), .mst_b_valid_i(b_valid), .mst_b_ready_o(b_ready),
      .mst_ar_addr_o(ar_addr), .mst_ar_size_o(ar_size), .mst_ar_len_o(ar_len),
      .mst_ar_burst_o(ar_burst), .mst_ar_lock_o(ar_lock), .mst_ar_id_o(ar_id),
      .mst_ar_valid_o(ar_valid), .mst_ar_ready_i(ar_ready),
      .mst_r_data_i(r_data), .mst_r_resp_i(r_resp), .mst_r_valid_i(r_valid),
      .mst_r_ready_o(r_ready)
   );

   // Beat counting and valid/payload stability watch on the master channels.
   always @(posedge clk) begin
      if (aw_valid && aw_ready) aw_beats <= aw_beats + 1;
      if (w_valid && w_ready) w_beats <= w_beats + 1;
      if (ar_valid && ar_ready) ar_beats <= ar_beats + 1;
      if (b_valid && b_ready) b_beats <= b_beats + 1;
      if (r_valid && r_ready) r_beats <= r_beats + 1;
      if ((aw_pend && (!aw_valid || aw_addr != aw_addr_prev)) ||
          (w_pend && (!w_valid || w_data != w_data_prev)) ||
          (ar_pend && (!ar_valid || ar_addr != ar_addr_prev))) stab_err <= stab_err + 1;
      aw_pend      <= !rst && aw_valid && !aw_ready;
      w_pend       <= !rst && w_valid && !w_ready;
      ar_pend      <= !rst && ar_valid && !ar_ready;
      aw_addr_prev <= aw_addr;
      ar_addr_prev <= ar_addr;
      w_data_prev  <= w_data;
   end

   task automatic issue(input logic [3:0] op, input logic [47:0] addr, input logic [1:0] size,
                        input logic [63:0] data, input logic [7:0] strb);
      int waited;
      waited = 0;
      req_op = op; req_addr = addr; req_size = size; req_data = data; req_strb = strb;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (waited >= 20) begin
         miscompares++;
         $display("[TB] FAIL issue_timeout: req_ready=%b, required 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_error} !== 8'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got %b, required 00000000",
                  {req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_error});
      end
      vectors++;
      if (rsp_data !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_rsp_data: got %h, required 0", rsp_data);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({req_ready, aw_valid, ar_valid, rsp_valid} !== 4'b1000) begin
         miscompares++;
         $display("[TB] FAIL post_reset_ready: got %b, required 1000", {req_ready, aw_valid, ar_valid, rsp_valid});
      end
   endtask

   task automatic test_load;
      ar_ready = 1'b1;
      issue(OP_LOAD, 48'h1000, 2'd3, 64'h0, 8'hFF);
      vectors++;
      if ({ar_valid, ar_lock, aw_valid, w_valid} !== 4'b1000 || ar_addr !== 48'h1000) begin
         miscompares++;
         $display("[TB] FAIL load_ar: valid/lock/aw/w=%b addr=%h, required 1000 addr=1000",
                  {ar_valid, ar_lock, aw_valid, w_valid}, ar_addr);
      end
      vectors++;
      if ({ar_size, ar_len, ar_burst, ar_id} !== {3'd3, 8'd0, 2'b01, 4'd0}) begin
         miscompares++;
         $display("[TB] FAIL load_ar_attrs: got %h, required %h", {ar_size, ar_len, ar_burst, ar_id},
                  {3'd3, 8'd0, 2'b01, 4'd0});
      end
      r_valid = 1'b1; r_data = 64'hDEADBEEF_00000001; r_resp = 2'b00;
      @(negedge clk);
      vectors++;
      if ({ar_valid, r_ready, rsp_valid} !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL load_wait_r: got %b, required 010", {ar_valid, r_ready, rsp_valid});
      end
      @(negedge clk);
      r_valid = 1'b0;
      vectors++;
      if ({rsp_valid, rsp_error} !== 2'b10 || rsp_data !== 64'hDEADBEEF_00000001) begin
         miscompares++;
         $display("[TB] FAIL load_rsp: valid/err=%b data=%h, required 10 data=deadbeef00000001",
                  {rsp_valid, rsp_error}, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; ar_ready = 1'b0;
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL load_done: got %b, required 01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_back_to_back;
      ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b00; r_data = 64'h1111; rsp_ready = 1'b1;
      issue(OP_LOAD, 48'h3000, 2'd3, 64'h0, 8'hFF);
      repeat (2) @(negedge clk);
      req_op = OP_LOAD; req_addr = 48'h3008; req_valid = 1'b1; r_data = 64'h2222;
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL b2b_first_rsp: got %b, required 10", {rsp_valid, req_ready});
      end
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL b2b_ready: got %b, required 01", {rsp_valid, req_ready});
      end
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if (ar_valid !== 1'b1 || ar_addr !== 48'h3008) begin
         miscompares++;
         $display("[TB] FAIL b2b_second_ar: valid=%b addr=%h, required 1 addr=3008", ar_valid, ar_addr);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'h2222) begin
         miscompares++;
         $display("[TB] FAIL b2b_second_rsp: valid=%b data=%h, required 1 data=2222", rsp_valid, rsp_data);
      end
      @(negedge clk);
      rsp_ready = 1'b0; r_valid = 1'b0; ar_ready = 1'b0;
   endtask

   task automatic test_amo_add;
      int r0, b0;
      r0 = r_beats; b0 = b_beats;
      aw_ready = 1'b1; w_ready = 1'b1;
      issue(OP_ADD, 48'h2000, 2'd3, 64'd5, 8'hFF);
      vectors++;
      if ({aw_valid, w_valid, aw_lock, w_last, ar_valid} !== 5'b11010 || aw_atop !== 6'b100000) begin
         miscompares++;
         $display("[TB] FAIL add_aw: ctrl=%b atop=%b, required 11010 atop=100000",
                  {aw_valid, w_valid, aw_lock, w_last, ar_valid}, aw_atop);
      end
      vectors++;
      if (aw_addr !== 48'h2000 || w_data !== 64'd5 || w_strb !== 8'hFF ||
          {aw_size, aw_len, aw_burst, aw_id} !== {3'd3, 8'd0, 2'b01, 4'd0}) begin
         miscompares++;
         $display("[TB] FAIL add_payload: addr=%h data=%h strb=%h attrs=%h, required 2000/5/ff/%h",
                  aw_addr, w_data, w_strb, {aw_size, aw_len, aw_burst, aw_id}, {3'd3, 8'd0, 2'b01, 4'd0});
      end
      @(negedge clk);
      vectors++;
      if ({aw_valid, w_valid, b_ready, r_ready} !== 4'b0011) begin
         miscompares++;
         $display("[TB] FAIL add_wait_br: got %b, required 0011", {aw_valid, w_valid, b_ready, r_ready});
      end
      r_valid = 1'b1; r_data = 64'h77; r_resp = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         r_valid = 1'b0;
         vectors++;
         if ({rsp_valid, b_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL add_hold_%0d: got %b, required 01", i, {rsp_valid, b_ready});
         end
      end
      b_valid = 1'b1; b_resp = 2'b00;
      @(negedge clk);
      b_valid = 1'b0;
      vectors++;
      if ({rsp_valid, rsp_error} !== 2'b10 || rsp_data !== 64'h77) begin
         miscompares++;
         $display("[TB] FAIL add_rsp: valid/err=%b data=%h, required 10 data=77", {rsp_valid, rsp_error}, rsp_data);
      end
      vectors++;
      if (r_beats - r0 !== 1 || b_beats - b0 !== 1) begin
         miscompares++;
         $display("[TB] FAIL add_beats: r=%0d b=%0d, required 1 1", r_beats - r0, b_beats - b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
   endtask

   task automatic test_amo_and;
      aw_ready = 1'b1; w_ready = 1'b1;
      issue(OP_AND, 48'h2040, 2'd3, 64'h00FF, 8'hFF);
      vectors++;
      if (aw_atop !== 6'b100001 || w_data !== 64'hFFFF_FFFF_FFFF_FF00) begin
         miscompares++;
         $display("[TB] FAIL and_clr: atop=%b data=%h, required 100001 data=ffffffffffffff00", aw_atop, w_data);
      end
      @(negedge clk);
      b_valid = 1'b1; b_resp = 2'b00; r_valid = 1'b1; r_resp = 2'b00; r_data = 64'hAAAA;
      @(negedge clk);
      b_valid = 1'b0; r_valid = 1'b0;
      vectors++;
      if ({rsp_valid, rsp_error} !== 2'b10 || rsp_data !== 64'hAAAA) begin
         miscompares++;
         $display("[TB] FAIL and_rsp: valid/err=%b data=%h, required 10 data=aaaa", {rsp_valid, rsp_error}, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
   endtask

   task automatic test_sc;
      aw_ready = 1'b1; w_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         issue(OP_SC, 48'h4000, 2'd3, 64'h55, 8'hFF);
         vectors++;
         if ({aw_lock, aw_atop} !== {1'b1, 6'b000000}) begin
            miscompares++;
            $display("[TB] FAIL sc_aw_%0d: lock/atop=%b, required 1000000", k, {aw_lock, aw_atop});
         end
         @(negedge clk);
         vectors++;
         if ({b_ready, r_ready} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL sc_wait_b_%0d: got %b, required 10", k, {b_ready, r_ready});
         end
         b_valid = 1'b1; b_resp = (k == 0) ? 2'b01 : 2'b00;
         @(negedge clk);
         b_valid = 1'b0;
         vectors++;
         if ({rsp_valid, rsp_error} !== 2'b10 || rsp_data !== ((k == 0) ? 64'd0 : 64'd1)) begin
            miscompares++;
            $display("[TB] FAIL sc_rsp_%0d: valid/err=%b data=%h, required 10 data=%0d",
                     k, {rsp_valid, rsp_error}, rsp_data, k);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
      aw_ready = 1'b0; w_ready = 1'b0;
   endtask

   task automatic test_store_split;
      int aw0, w0;
      aw0 = aw_beats; w0 = w_beats;
      aw_ready = 1'b0; w_ready = 1'b1;
      issue(OP_STORE, 48'h5000, 2'd2, 64'h1234, 8'h0F);
      vectors++;
      if ({aw_valid, w_valid, aw_lock} !== 3'b110 || aw_atop !== 6'd0 || aw_size !== 3'd2 || w_strb !== 8'h0F) begin
         miscompares++;
         $display("[TB] FAIL store_issue: ctrl=%b atop=%b size=%0d strb=%h, required 110 0 2 0f",
                  {aw_valid, w_valid, aw_lock}, aw_atop, aw_size, w_strb);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if ({aw_valid, w_valid} !== 2'b10 || aw_addr !== 48'h5000) begin
            miscompares++;
            $display("[TB] FAIL store_aw_hold_%0d: aw/w=%b addr=%h, required 10 addr=5000",
                     i, {aw_valid, w_valid}, aw_addr);
         end
      end
      aw_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL store_wait_b: got %b, required 001", {aw_valid, w_valid, b_ready});
      end
      b_valid = 1'b1; b_resp = 2'b00;
      @(negedge clk);
      b_valid = 1'b0;
      vectors++;
      if ({rsp_valid, rsp_error} !== 2'b10 || rsp_data !== 64'd0) begin
         miscompares++;
         $display("[TB] FAIL store_rsp: valid/err=%b data=%h, required 10 data=0", {rsp_valid, rsp_error}, rsp_data);
      end
      vectors++;
      if (aw_beats - aw0 !== 1 || w_beats - w0 !== 1) begin
         miscompares++;
         $display("[TB] FAIL store_beats: aw=%0d w=%0d, required 1 1", aw_beats - aw0, w_beats - w0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
   endtask

   task automatic test_lr_decerr;
      ar_ready = 1'b1;
      issue(OP_LR, 48'h6000, 2'd3, 64'h0, 8'hFF);
      vectors++;
      if ({ar_valid, ar_lock} !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL lr_ar: valid/lock=%b, required 11", {ar_valid, ar_lock});
      end
      r_valid = 1'b1; r_data = 64'hABCD; r_resp = 2'b11;
      repeat (2) @(negedge clk);
      r_valid = 1'b0; ar_ready = 1'b0;
      req_op = OP_LOAD; req_addr = 48'h7000; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if ({rsp_valid, rsp_error, req_ready} !== 3'b110 || rsp_data !== 64'hABCD) begin
            miscompares++;
            $display("[TB] FAIL lr_hold_%0d: valid/err/ready=%b data=%h, required 110 data=abcd",
                     i, {rsp_valid, rsp_error, req_ready}, rsp_data);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL lr_done: got %b, required 01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_reset_mid;
      aw_ready = 1'b1; w_ready = 1'b1;
      issue(OP_ADD, 48'h8000, 2'd3, 64'd1, 8'hFF);
      @(negedge clk);
      aw_ready = 1'b0; w_ready = 1'b0;
      r_valid = 1'b1; r_data = 64'h99; r_resp = 2'b10;
      @(negedge clk);
      r_valid = 1'b0;
      vectors++;
      if ({b_ready, r_ready, rsp_valid} !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL mid_wait_br: got %b, required 110", {b_ready, r_ready, rsp_valid});
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_error} !== 8'b0 ||
          rsp_data !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: ctrl=%b data=%h, required 00000000 data=0",
                  {req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_error}, rsp_data);
      end
      rst = 1'b0;
      @(negedge clk);
      ar_ready = 1'b1;
      issue(OP_LOAD, 48'h9000, 2'd3, 64'h0, 8'hFF);
      r_valid = 1'b1; r_data = 64'h4242; r_resp = 2'b00;
      repeat (2) @(negedge clk);
      r_valid = 1'b0; ar_ready = 1'b0;
      vectors++;
      if ({rsp_valid, rsp_error} !== 2'b10 || rsp_data !== 64'h4242) begin
         miscompares++;
         $display("[TB] FAIL mid_after_load: valid/err=%b data=%h, required 10 data=4242",
                  {rsp_valid, rsp_error}, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_protocol;
      vectors++;
      if (stab_err !== 0) begin
         miscompares++;
         $display("[TB] FAIL valid_stability: %0d violations, required 0", stab_err);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_op = '0; req_size = '0; req_data = '0; req_strb = '0;
      rsp_ready = 1'b0;
      aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
      b_valid = 1'b0; b_resp = '0; r_valid = 1'b0; r_data = '0; r_resp = '0;
      @(negedge clk);
      test_reset;
      test_load;
      test_back_to_back;
      test_amo_add;
      test_amo_and;
      test_sc;
      test_store_split;
      test_lr_decerr;
      test_reset_mid;
      test_protocol;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
